// File: rtl/mem_access.sv
// Memory-access stage: one data-bus transaction per accepted load/store, then a write-back strobe.
// Optional bus-ack timeout is compiled in by defining MEM_TIMEOUT_EN.
module mem_access #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] BAD_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] mem_o,
  output logic        wd_q_readin_o,
  output logic        busy_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_rs2;
  logic        r_is_load;
  logic        r_is_store;
  logic        r_misalign;
  logic [31:0] r_mem;

  logic        w_in_load;
  logic        w_in_store;
  logic        w_in_mem;
  logic        w_in_aligned;
  logic        w_go_bus;
  logic        w_in_misalign;
  logic        w_accept;
  logic        w_ack;
  logic        w_expire;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_data;

  logic        w_unused_ir;
  assign w_unused_ir = ^{ir_i[31:15], ir_i[11:7]};

  // Classification of the incoming instruction; unsupported funct3 codes fall through as bypass.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_in_load    = (ir_i[6:0] == OPC_LOAD) &&
                   (ir_i[14:12] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    w_in_store   = (ir_i[6:0] == OPC_STORE) &&
                   (ir_i[14:12] inside {3'b000, 3'b001, 3'b010});
    w_in_mem     = w_in_load || w_in_store;
    w_in_aligned = 1'b1;
    case (ir_i[13:12])
      2'b00:   w_in_aligned = 1'b1;
      2'b01:   w_in_aligned = ~addr_i[0];
      2'b10:   w_in_aligned = (addr_i[1:0] == 2'b00);
      default: w_in_aligned = 1'b0;
    endcase
    w_go_bus      = w_in_mem && w_in_aligned;
    w_in_misalign = w_in_mem && !w_in_aligned;
  end

  assign w_accept = (r_state == S_IDLE) && start_i;
  assign w_ack    = (r_state == S_REQ) && dmem_ack_i;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // The limit cycle is the last REQ cycle; an ack arriving on it still completes normally.
  assign w_expire = (r_state == S_REQ) && !dmem_ack_i &&
                    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_expire     = 1'b0;
  assign w_unused_cfg = ^{BAD_DATA, TIMEOUT_CYCLES};
`endif

  // Store lane placement from the latched access size and address.
  always_comb begin
    w_be    = 4'hF;
    w_wdata = r_rs2;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_rs2[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata = {2{r_rs2[15:0]}};
      end
      default: begin
        w_be    = 4'hF;
        w_wdata = r_rs2;
      end
    endcase
  end

  // Load lane extraction with sign or zero extension.
  always_comb begin
    w_lane_byte = dmem_rdata_i[{r_addr[1:0], 3'b000} +: 8];
    w_lane_half = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    w_load_data = dmem_rdata_i;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_lane_byte[7]}}, w_lane_byte};
      3'b100:  w_load_data = {24'h000000, w_lane_byte};
      3'b001:  w_load_data = {{16{w_lane_half[15]}}, w_lane_half};
      3'b101:  w_load_data = {16'h0000, w_lane_half};
      default: w_load_data = dmem_rdata_i;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the latched operands are reset too, so the bus outputs and mem_o are clean 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_funct3   <= 3'b000;
      r_addr     <= 32'h0;
      r_rs2      <= 32'h0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_misalign <= 1'b0;
      r_mem      <= 32'h0;
`ifdef MEM_TIMEOUT_EN
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_funct3   <= ir_i[14:12];
        r_addr     <= addr_i;
        r_rs2      <= rs2_i;
        r_is_load  <= w_in_load;
        r_is_store <= w_in_store;
        r_misalign <= w_in_misalign;
      end
      if (w_ack && r_is_load) begin
        r_mem <= w_load_data;
      end
`ifdef MEM_TIMEOUT_EN
      if (w_accept) begin
        r_timeout <= 1'b0;
      end
      if (r_state == S_REQ && !dmem_ack_i && !w_expire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
        if (r_is_load) begin
          r_mem <= BAD_DATA;
        end
      end
`endif
    end
  end

  always_comb begin
    w_next_state  = r_state;
    busy_o        = (r_state != S_IDLE);
    wd_q_readin_o = 1'b0;
    misalign_o    = 1'b0;
    timeout_o     = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    dmem_addr_o   = 32'h0;
    dmem_be_o     = 4'h0;
    dmem_wdata_o  = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_state = w_go_bus ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = r_is_store;
        dmem_addr_o  = {r_addr[31:2], 2'b00};
        dmem_be_o    = w_be;
        dmem_wdata_o = w_wdata;
        if (dmem_ack_i || w_expire) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        wd_q_readin_o = 1'b1;
        misalign_o    = r_misalign;
`ifdef MEM_TIMEOUT_EN
        timeout_o     = r_timeout;
`endif
        w_next_state  = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign mem_o = r_mem;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized instructions against
// an arithmetic model of access size, alignment, lane placement and extension.
module tb_mem_access;

  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_OP    = 7'h33;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [31:0] ir_i;
  logic [31:0] addr_i;
  logic [31:0] rs2_i;
  logic [31:0] mem_o;
  logic        wd_q_readin_o;
  logic        busy_o;
  logic        misalign_o;
  logic        timeout_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_mem  = 32'h0;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .ir_i          (ir_i),
    .addr_i        (addr_i),
    .rs2_i         (rs2_i),
    .mem_o         (mem_o),
    .wd_q_readin_o (wd_q_readin_o),
    .busy_o        (busy_o),
    .misalign_o    (misalign_o),
    .timeout_o     (timeout_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_rdata_i  (dmem_rdata_i),
    .dmem_ack_i    (dmem_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic logic [31:0] size_mask(input int unsigned size);
    if (size >= 4) return 32'hFFFF_FFFF;
    return (32'd1 << (8 * size)) - 32'd1;
  endfunction

  // Shift the addressed bytes down, keep the access width, then sign-fill for signed loads.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int unsigned size;
    logic [31:0] mask;
    logic [31:0] v;
    size = acc_size(f3);
    mask = size_mask(size);
    v    = (rdata >> (8 * addr[1:0])) & mask;
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (acc_size(f3))
      1:       return {24'h0, rs2[7:0]} * 32'h0101_0101;
      2:       return {16'h0, rs2[15:0]} * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned size;
    size = acc_size(f3);
    return 32'((((32'd1 << size) - 32'd1) << addr[1:0]) & 32'hF);
  endfunction

  // One instruction: start pulse, optional bus phase with ack after `delay` wait cycles,
  // strobe cycle, then a cycle that must be idle. `poke` raises start_i while busy.
  task automatic run_op(input logic [31:0] ir, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int delay, input bit poke);
    logic [2:0] f3;
    logic [6:0] opc;
    bit         is_ld;
    bit         is_st;
    bit         aligned;
    bit         on_bus;
    f3      = ir[14:12];
    opc     = ir[6:0];
    is_ld   = (opc == OPC_LOAD) && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    is_st   = (opc == OPC_STORE) && (f3 inside {3'b000, 3'b001, 3'b010});
    aligned = (addr % acc_size(f3)) == 0;
    on_bus  = (is_ld || is_st) && aligned;

    @(negedge clk);
    start_i = 1'b1;
    ir_i    = ir;
    addr_i  = addr;
    rs2_i   = rs2;
    @(negedge clk);
    start_i = 1'b0;
    ir_i    = $urandom;
    addr_i  = $urandom;
    rs2_i   = $urandom;
    if (on_bus) begin
      for (int k = 0; k <= delay; k++) begin
        check("req_held", 32'(dmem_req_o), 32'd1);
        check("no_early_strobe", 32'(wd_q_readin_o), 32'd0);
        check("bus_addr", dmem_addr_o, {addr[31:2], 2'b00});
        check("bus_we", 32'(dmem_we_o), 32'(is_st));
        if (is_st) begin
          check("bus_be", 32'(dmem_be_o), model_be(f3, addr));
          check("bus_wdata", dmem_wdata_o, model_wdata(f3, rs2));
        end
        start_i      = poke && (k == 0);
        dmem_ack_i   = (k == delay);
        dmem_rdata_i = (k == delay) ? rdata : $urandom;
        @(negedge clk);
        start_i = 1'b0;
      end
      dmem_ack_i = 1'b0;
      if (is_ld) exp_mem = model_load(f3, addr, rdata);
    end
    check("strobe", 32'(wd_q_readin_o), 32'd1);
    check("misalign", 32'(misalign_o), 32'((is_ld || is_st) && !aligned));
    check("timeout", 32'(timeout_o), 32'd0);
    check("req_off_at_strobe", 32'(dmem_req_o), 32'd0);
    check("busy_at_strobe", 32'(busy_o), 32'd1);
    check("mem_o", mem_o, exp_mem);
    start_i = poke;
    @(negedge clk);
    start_i = 1'b0;
    check("strobe_single", 32'(wd_q_readin_o), 32'd0);
    check("busy_cleared", 32'(busy_o), 32'd0);
    check("idle_no_req", 32'(dmem_req_o), 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    start_i      = 1'b0;
    ir_i         = 32'h0;
    addr_i       = 32'h0;
    rs2_i        = 32'h0;
    dmem_rdata_i = 32'h0;
    dmem_ack_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_o", mem_o, 32'h0);
    check("rst_strobe", 32'(wd_q_readin_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_req", 32'(dmem_req_o), 32'd0);
    check("rst_bus_addr", dmem_addr_o, 32'h0);
    check("rst_flags", 32'({misalign_o, timeout_o, dmem_we_o, dmem_be_o}), 32'h0);
    reset = 1'b1;

    // LW aligned, ack in the first REQ cycle.
    run_op(32'h0000_2003, 32'h0000_0100, 32'h0, 32'h8000_00F0, 0, 1'b0);
    check("lw_value", mem_o, 32'h8000_00F0);
    // LB / LBU on the top lane.
    run_op(32'h0000_0003, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 1, 1'b0);
    check("lb_value", mem_o, 32'hFFFF_FF80);
    run_op(32'h0000_4003, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0, 1'b0);
    check("lbu_value", mem_o, 32'h0000_0080);
    // SH upper half after 3 wait cycles, with a start_i poke while busy.
    run_op(32'h0000_1023, 32'h0000_0022, 32'h1234_ABCD, 32'h0, 3, 1'b1);
    check("sh_keeps_mem", mem_o, 32'h0000_0080);
    // Misaligned LW and an R-type both bypass the bus.
    run_op(32'h0000_2003, 32'h0000_0102, 32'h0, 32'h0, 0, 1'b0);
    run_op(32'h0000_0033, 32'h0000_0102, 32'h0, 32'h0, 0, 1'b1);
    // Misaligned LH, aligned LHU on the upper half.
    run_op(32'h0000_1003, 32'h0000_0011, 32'h0, 32'h0, 0, 1'b0);
    run_op(32'h0000_5003, 32'h0000_0012, 32'h0, 32'h9876_5432, 2, 1'b0);
    check("lhu_value", mem_o, 32'h0000_9876);

    // Reset in the middle of a bus phase.
    @(negedge clk);
    start_i = 1'b1;
    ir_i    = 32'h0000_2003;
    addr_i  = 32'h0000_0200;
    @(negedge clk);
    start_i = 1'b0;
    check("pre_reset_req", 32'(dmem_req_o), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("reset_drops_req", 32'(dmem_req_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_mem_o", mem_o, 32'h0);
    exp_mem = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_strobe_after_reset", 32'(wd_q_readin_o), 32'd0);
    end
    run_op(32'h0000_2003, 32'h0000_0200, 32'h0, 32'h0BAD_CAFE, 1, 1'b0);

`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    start_i = 1'b1;
    ir_i    = 32'h0000_2003;
    addr_i  = 32'h0000_0040;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("to_req_held", 32'(dmem_req_o), 32'd1);
      @(negedge clk);
    end
    check("to_req_drop", 32'(dmem_req_o), 32'd0);
    check("to_strobe", 32'(wd_q_readin_o), 32'd1);
    check("to_flag", 32'(timeout_o), 32'd1);
    check("to_mem", mem_o, 32'hDEAD_BEEF);
    exp_mem = 32'hDEAD_BEEF;
    @(negedge clk);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ir;
      ir = $urandom;
      case ($urandom_range(0, 2))
        0:       ir[6:0] = OPC_LOAD;
        1:       ir[6:0] = OPC_STORE;
        default: ir[6:0] = OPC_OP;
      endcase
      run_op(ir, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
